// File: rtl/mac_bank_pkg.sv
// Shared arithmetic helpers for the pipelined MAC bank.
// Contents: default sample/fraction widths and the saturating fixed-point
// multiply and add used by every lane. The helpers take the operand width as
// an argument so one definition serves any DATA_W up to 32 bits.
package mac_bank_pkg;

  localparam int unsigned DataWDefault = 16;
  localparam int unsigned FracWDefault = 8;

  // Clamp a wide signed value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned       dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Full-precision product, arithmetic shift (rounds toward -inf), saturate.
  function automatic logic signed [63:0] sat_mul(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned       dw,
                                                 input int unsigned       fw);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    p = p >>> fw;
    return sat_clamp(p, dw);
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned       dw);
    return sat_clamp(64'(a) + 64'(b), dw);
  endfunction

endpackage

// File: rtl/mac_bank_pipe_if.sv
// Beat/control/readout bundle of mac_bank_pipe.
// master: drives beats, clear requests and the readout bank select.
// slave : the MAC block; returns in_ready, acc_out and the done pulse.
interface mac_bank_pipe_if #(
  parameter int unsigned LANES  = 56,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BANK_W = 1
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_sample;
  logic [LANES*DATA_W-1:0] in_weights;
  logic [BANK_W-1:0]       in_bank;
  logic                    clr;
  logic [BANK_W-1:0]       clr_bank;
  logic [BANK_W-1:0]       rd_bank;
  logic [LANES*DATA_W-1:0] acc_out;
  logic                    done;
  logic [BANK_W-1:0]       done_bank;

  modport master (
    output in_valid, in_sample, in_weights, in_bank, clr, clr_bank, rd_bank,
    input  in_ready, acc_out, done, done_bank
  );

  modport slave (
    input  in_valid, in_sample, in_weights, in_bank, clr, clr_bank, rd_bank,
    output in_ready, acc_out, done, done_bank
  );
endinterface

// File: rtl/mac_lane.sv
// One MAC lane: stage 1 registers the saturated product of the broadcast
// sample and this lane's weight; stage 2 adds it into the selected bank.
// Ports: clk/rst; accept_i loads stage 1; wr_en_i/wr_bank_i commit stage 2
// (already gated against a same-bank clear by the top); clr_i/clr_bank_i
// zero one bank; acc_o exposes all bank accumulators, bank b at
// [b*DATA_W +: DATA_W].
module mac_lane
  import mac_bank_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned FRAC_W = FracWDefault,
  parameter int unsigned BANKS  = 2,
  parameter int unsigned BANK_W = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    accept_i,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic signed [DATA_W-1:0] weight_i,
  input  logic                    wr_en_i,
  input  logic [BANK_W-1:0]       wr_bank_i,
  input  logic                    clr_i,
  input  logic [BANK_W-1:0]       clr_bank_i,
  output logic [BANKS*DATA_W-1:0] acc_o
);

  logic signed [DATA_W-1:0] prod_d, prod_q;
  logic signed [DATA_W-1:0] acc_q [BANKS];
  logic signed [DATA_W-1:0] sum_d [BANKS];

  always_comb begin
    prod_d = DATA_W'(sat_mul(32'(sample_i), 32'(weight_i), DATA_W, FRAC_W));
    acc_o  = '0;
    for (int b = 0; b < BANKS; b++) begin
      sum_d[b] = DATA_W'(sat_add(32'(acc_q[b]), 32'(prod_q), DATA_W));
      acc_o[b*DATA_W +: DATA_W] = acc_q[b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      for (int b = 0; b < BANKS; b++) acc_q[b] <= '0;
    end else begin
      if (accept_i) prod_q <= prod_d;
      for (int b = 0; b < BANKS; b++) begin
        if (clr_i && clr_bank_i == BANK_W'(b)) begin
          acc_q[b] <= '0;
        end else if (wr_en_i && wr_bank_i == BANK_W'(b)) begin
          acc_q[b] <= sum_d[b];
        end
      end
    end
  end

endmodule

// File: rtl/mac_bank_pipe.sv
// Pipelined multi-lane signed fixed-point MAC with banked accumulators.
// Ports: clk, rst (async, active high); bus (slave modport) carries the
// valid/ready beat (sample, per-lane weights, target bank), the per-bank
// clear request, the readout select/accumulators and the done pulse.
// The top owns the handshake, stage-1 valid/bank, per-bank term counters,
// done generation and the readout mux; arithmetic lives in mac_lane.
module mac_bank_pipe
  import mac_bank_pkg::*;
#(
  parameter int unsigned LANES  = 56,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned FRAC_W = FracWDefault,
  parameter int unsigned BANKS  = 2,
  parameter int unsigned TERMS  = 784,
  parameter int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1,
  parameter int unsigned CNT_W  = (TERMS > 1) ? $clog2(TERMS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  mac_bank_pipe_if.slave bus
);

  logic              accept;
  logic              wr_en;
  logic              s1_valid_q;
  logic [BANK_W-1:0] s1_bank_q;
  logic [CNT_W-1:0]  cnt_q [BANKS];
  logic [CNT_W-1:0]  cnt_sel;
  logic              done_q;
  logic [BANK_W-1:0] done_bank_q;
  logic [BANKS*DATA_W-1:0] lane_acc [LANES];
  logic [LANES*DATA_W-1:0] acc_out_c;

  assign bus.in_ready = !bus.clr;
  assign accept       = bus.in_valid && !bus.clr;
  // A clear of the bank being written wins; the in-flight term is dropped.
  assign wr_en        = s1_valid_q && !(bus.clr && bus.clr_bank == s1_bank_q);

  always_comb begin
    cnt_sel = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (s1_bank_q == BANK_W'(b)) cnt_sel = cnt_q[b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_bank_q   <= '0;
      done_q      <= 1'b0;
      done_bank_q <= '0;
      for (int b = 0; b < BANKS; b++) cnt_q[b] <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) s1_bank_q <= bus.in_bank;
      done_q <= wr_en && (cnt_sel == CNT_W'(TERMS - 1));
      if (wr_en && (cnt_sel == CNT_W'(TERMS - 1))) done_bank_q <= s1_bank_q;
      for (int b = 0; b < BANKS; b++) begin
        if (bus.clr && bus.clr_bank == BANK_W'(b)) begin
          cnt_q[b] <= '0;
        end else if (wr_en && s1_bank_q == BANK_W'(b)) begin
          cnt_q[b] <= (cnt_q[b] == CNT_W'(TERMS - 1)) ? '0 : cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mac_lane #(
      .DATA_W(DATA_W),
      .FRAC_W(FRAC_W),
      .BANKS (BANKS),
      .BANK_W(BANK_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .accept_i  (accept),
      .sample_i  (bus.in_sample),
      .weight_i  (bus.in_weights[k*DATA_W +: DATA_W]),
      .wr_en_i   (wr_en),
      .wr_bank_i (s1_bank_q),
      .clr_i     (bus.clr),
      .clr_bank_i(bus.clr_bank),
      .acc_o     (lane_acc[k])
    );
  end

  always_comb begin
    acc_out_c = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int b = 0; b < BANKS; b++) begin
        if (bus.rd_bank == BANK_W'(b)) begin
          acc_out_c[k*DATA_W +: DATA_W] = lane_acc[k][b*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign bus.acc_out   = acc_out_c;
  assign bus.done      = done_q;
  assign bus.done_bank = done_bank_q;

endmodule

// File: doc/mac_bank_pipe.md
Name: mac_bank_pipe

Overview:
- Parametrised, pipelined successor of the combinational multiply-add bank.
- LANES parallel signed fixed-point MAC lanes share one broadcast input sample and take a per-lane weight.
- Products accumulate into one of BANKS register-resident accumulator banks (e.g. bank 0 = hidden layer, bank 1 = output layer).
- Adds a valid/ready handshake, saturating arithmetic, per-bank term counters with done pulses, and per-bank clear.

Parameters:
- LANES, 56, number of parallel MAC lanes
- DATA_W, 16, signed sample/weight/accumulator width
- FRAC_W, 8, fractional bits (default format Q8.8)
- BANKS, 2, number of accumulator banks
- TERMS, 784, accumulated terms per bank before done
- BANK_W, $clog2(BANKS) (min 1), bank index width
- CNT_W, $clog2(TERMS) (min 1), term counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_sample  in  DATA_W  signed sample, broadcast to all lanes
- in_weights  in  LANES*DATA_W  lane k weight = bits [k*DATA_W +: DATA_W]
- in_bank  in  BANK_W  target accumulator bank
- clr  in  1  clear request
- clr_bank  in  BANK_W  bank to clear
- rd_bank  in  BANK_W  bank driven onto acc_out
- acc_out  out  LANES*DATA_W  accumulators of rd_bank, same lane packing
- done  out  1  one-cycle pulse: a bank completed TERMS terms
- done_bank  out  BANK_W  bank that completed; valid while done=1

Behaviour:
- Reset (async, rst=1): all accumulators 0, all counters 0, pipeline valids 0, done=0, done_bank=0. in_ready=1 once rst is low and clr is low.
- Handshake:
  - in_ready = !clr.
  - A beat is accepted when in_valid && in_ready at a rising edge.
  - No backpressure source other than clr. The pipeline never stalls.
- Stage 1 (accept edge t):
  - Per lane: full signed product DATA_W x DATA_W -> 2*DATA_W.
  - Arithmetic shift right FRAC_W (truncation toward -inf).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register the product with s1_valid and s1_bank.
- Stage 2 (edge t+1): acc[s1_bank][k] <= sat(acc[s1_bank][k] + prod[k]); saturating signed add, no wrap.
- acc_out:
  - Combinational mux of registered accumulators by rd_bank.
  - An accepted beat is visible at acc_out after edge t+1 (2-cycle latency from presentation).
- Counter (per bank), on each stage-2 write:
  - If cnt == TERMS-1: cnt <= 0, and done=1 with done_bank=bank on the following cycle (registered pulse).
  - Otherwise cnt <= cnt + 1.
  - Accumulators are NOT auto-cleared at done.
- Clear (clr=1 at edge, bank c=clr_bank):
  - acc[c][*] <= 0 and cnt[c] <= 0.
  - Clear has priority over a stage-2 write to the same bank: that term is dropped and no done is generated.
  - If s1_valid && s1_bank==c, s1_valid is killed.
  - Other banks are unaffected and keep accumulating.
- Back-to-back beats to alternating banks are legal every cycle.
- rst mid-operation discards in-flight beats immediately (asynchronous).

Decomposition:
- Package mac_bank_pkg:
  - default DATA_W/FRAC_W constants
  - function sat_mul(a,b) -> DATA_W (multiply, shift, saturate)
  - function sat_add(a,b) -> DATA_W
- Sub-module mac_lane:
  - one lane, both pipeline stages, BANKS accumulators, kill/clear inputs
  - generated LANES times
- Top level holds the handshake, the s1_bank/s1_valid registers, the counters, done logic and the rd_bank mux.

Test Plan:
- Basic MAC, LANES=4 (all other parameters default): rst; beat sample=0x0200, all weights=0x0180, bank 0 -> acc_out(rd_bank=0) lanes = 0x0300 exactly 2 cycles after presentation; bank 1 stays 0.
- Saturation: sample=0x7FFF, weight=0x7FFF -> lane 0x7FFF; then sample=0x8000, weight=0x7FFF on a zeroed bank -> 0x8000; two beats of product 0x7000 -> 0x7FFF (no wrap).
- Done counter, TERMS=4: 4 beats to bank 1 -> single done pulse with done_bank=1 after the 4th write; 5th beat -> no pulse, count restarts; accumulators retain the sum.
- Clear collision: beats to bank 0 on consecutive cycles, clr=1, clr_bank=0 in the cycle after the last beat -> in_ready=0 that cycle; bank 0 = 0 and count=0 (the in-flight beat is dropped); bank 1 is untouched.
- Interleave: alternate bank 0/1 beats every cycle with distinct weights -> each bank matches a reference model sum per lane.
- Reset mid-stream: assert rst asynchronously between edges with beats in flight -> all accumulators 0, done=0, no late write after rst release.
